decode_execute_register: RTL

- Pipeline boundary between the decode stage (opcode decoder plus register-file read) and the execute stage (scalar ALU / vector lanes).
- Captures the decoded control bundle, operands, immediate and destination address each cycle.
- Supports hold (stall), flush (bubble insertion) and a valid/ready handshake with execute, so multi-cycle execute operations can back-pressure decode.
- Keeps saturating stall and bubble counters for performance debug.

---
 rtl/de_pkg.sv | 53 +++++
 rtl/sat_counter.sv | 35 +++
 rtl/decode_execute_register.sv | 138 +++++++++++++
 3 files changed

// File: rtl/de_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | de_pkg: control bundle, opcodes and helpers shared by the decode    |
// | and execute stages.                                  Revision: 1.0 |
// +--------------------------------------------------------------------+
package de_pkg;

  localparam int CTRL_WIDTH = 14;

  typedef struct packed {
    logic       useScalarAlu;
    logic       isScalarOutput;
    logic       isScalarReg1;
    logic       isScalarReg2;
    logic       resultSelectorWB;
    logic       writeEnableScalarWB;
    logic       writeEnableVectorWB;
    logic       writeToMemoryEnableM;
    logic       useInmediate;
    logic [2:0] aluControl;
    logic       outFlagM;
    logic       spare;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_ADDI  = 5'd8;
  localparam logic [4:0] OP_LOAD  = 5'd9;
  localparam logic [4:0] OP_STORE = 5'd10;
  localparam logic [4:0] OP_BEQ   = 5'd11;
  localparam logic [4:0] OP_BNE   = 5'd12;
  localparam logic [4:0] OP_JMP   = 5'd13;
  localparam logic [4:0] OP_VADD  = 5'd14;
  localparam logic [4:0] OP_VSUB  = 5'd15;
  localparam logic [4:0] OP_VMUL  = 5'd16;
  localparam logic [4:0] OP_OUT   = 5'd17;
  localparam logic [4:0] OP_HALT  = 5'd18;

  // An empty slot must never carry a write enable into execute.
  function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : CTRL_NOP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter: up-counter that sticks at all-ones.     Revision: 1.0 |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/decode_execute_register.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_execute_register: D->E pipeline register with stall, flush, |
// | valid/ready handshake and perf counters.             Revision: 1.0 |
// +--------------------------------------------------------------------+
module decode_execute_register
  import de_pkg::*;
#(
  parameter int OPCODE_WIDTH   = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int LANES          = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int IMM_WIDTH      = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        validD,
  output logic                        readyD,
  input  logic                        readyE,
  input  logic                        flushE,
  input  logic [OPCODE_WIDTH-1:0]     opcodeD,
  input  logic [CTRL_WIDTH-1:0]       ctrlD,
  input  logic [DATA_WIDTH-1:0]       scalarRd1D,
  input  logic [DATA_WIDTH-1:0]       scalarRd2D,
  input  logic [LANES*DATA_WIDTH-1:0] vectorRd1D,
  input  logic [LANES*DATA_WIDTH-1:0] vectorRd2D,
  input  logic [IMM_WIDTH-1:0]        immD,
  input  logic [REG_ADDR_WIDTH-1:0]   rdAddrD,
  output logic                        validE,
  output logic [OPCODE_WIDTH-1:0]     opcodeE,
  output logic [CTRL_WIDTH-1:0]       ctrlE,
  output logic [DATA_WIDTH-1:0]       scalarRd1E,
  output logic [DATA_WIDTH-1:0]       scalarRd2E,
  output logic [LANES*DATA_WIDTH-1:0] vectorRd1E,
  output logic [LANES*DATA_WIDTH-1:0] vectorRd2E,
  output logic [IMM_WIDTH-1:0]        immE,
  output logic [REG_ADDR_WIDTH-1:0]   rdAddrE,
  output logic [CNT_WIDTH-1:0]        stallCountE,
  output logic [CNT_WIDTH-1:0]        bubbleCountE
);

  logic                        valid_q,  valid_d;
  ctrl_t                       ctrl_q,   ctrl_d;
  logic [OPCODE_WIDTH-1:0]     opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]       s1_q,     s1_d;
  logic [DATA_WIDTH-1:0]       s2_q,     s2_d;
  logic [LANES*DATA_WIDTH-1:0] v1_q,     v1_d;
  logic [LANES*DATA_WIDTH-1:0] v2_q,     v2_d;
  logic [IMM_WIDTH-1:0]        imm_q,    imm_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q,     rd_d;

  logic  ready_w;
  logic  load_w;
  ctrl_t ctrl_in_w;

  // Depends only on registered state and readyE, so no D->E combinational path.
  assign ready_w   = !valid_q || readyE;
  assign load_w    = ready_w && !flushE;
  assign ctrl_in_w = ctrlD;

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    if (flushE) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (load_w) begin
      valid_d  = validD;
      ctrl_d   = ctrl_gate(validD, ctrl_in_w);
      opcode_d = opcodeD;
      s1_d     = scalarRd1D;
      s2_d     = scalarRd2D;
      v1_d     = vectorRd1D;
      v2_d     = vectorRd2D;
      imm_d    = immD;
      rd_d     = rdAddrD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_NOP;
      opcode_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (validD && !ready_w && !flushE),
    .count (stallCountE)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushE && (valid_q || validD)),
    .count (bubbleCountE)
  );

  assign readyD     = ready_w;
  assign validE     = valid_q;
  assign ctrlE      = ctrl_q;
  assign opcodeE    = opcode_q;
  assign scalarRd1E = s1_q;
  assign scalarRd2E = s2_q;
  assign vectorRd1E = v1_q;
  assign vectorRd2E = v2_q;
  assign immE       = imm_q;
  assign rdAddrE    = rd_q;

endmodule
`default_nettype wire
